// File: rtl/wb_tmr_regfile.sv
// Wishbone register bank whose data registers are held as three copies each,
// read through a bitwise majority vote, with a background scrubber and a fault-injection port.
module wb_tmr_regfile #(
   parameter logic [31:0] BASE_ADDR = 32'h3000_0000,
   parameter logic [31:0] ADDR_MASK = 32'hFFFF_FF00,
   parameter int          NREGS     = 8
) (
   input  logic                wb_clk_i,
   input  logic                wb_rst_i,
   input  logic                wbs_cyc_i,
   input  logic                wbs_stb_i,
   input  logic                wbs_we_i,
   input  logic [3:0]          wbs_sel_i,
   input  logic [31:0]         wbs_adr_i,
   input  logic [31:0]         wbs_dat_i,
   output logic                wbs_ack_o,
   output logic [31:0]         wbs_dat_o,
   output logic [2:0]          irq,
   input  logic                inject_i,
   input  logic [3:0]          inject_reg_i,
   input  logic [1:0]          inject_copy_i,
   input  logic [4:0]          inject_bit_i,
   output logic [NREGS*32-1:0] reg_o
);
   localparam int        IW         = $clog2(NREGS);
   localparam logic [5:0] OFF_STATUS = 6'h10;
   localparam logic [5:0] OFF_CTRL   = 6'h11;

   typedef enum logic {IDLE, ACK} state_t;

   state_t         state, state_nxt;
   logic [31:0]    cp [3][NREGS];
   logic [31:0]    voted [NREGS];
   logic [IW-1:0]  ptr;
   logic [15:0]    err_cnt;
   logic           err_pend, irq_en, irq_q;
   logic [31:0]    dat_q, rd_data, wr_val;

   function automatic logic [31:0] vote3(input logic [31:0] a, input logic [31:0] b,
                                         input logic [31:0] c);
      return (a & b) | (a & c) | (b & c);
   endfunction

   for (genvar r = 0; r < NREGS; r++) begin : g_vote
      assign voted[r]            = vote3(cp[0][r], cp[1][r], cp[2][r]);
      assign reg_o[r*32 +: 32]   = voted[r];
   end

   // Bus decode: only an IDLE-state request commits, so each access acts exactly once.
   logic          hit, req, wr, wr_data, off_is_data;
   logic [5:0]    off;
   logic [IW-1:0] wr_idx, inj_idx;
   logic          inj_ok, inj_live, scrub_bad, scrub_do;

   assign hit         = (wbs_adr_i & ADDR_MASK) == BASE_ADDR;
   assign off         = wbs_adr_i[7:2];
   assign off_is_data = off < 6'(NREGS);
   assign wr_idx      = off[IW-1:0];
   assign req         = (state == IDLE) && wbs_cyc_i && wbs_stb_i && hit;
   assign wr          = req && wbs_we_i;
   assign wr_data     = wr && off_is_data;

   assign inj_idx   = inject_reg_i[IW-1:0];
   assign inj_ok    = inject_i && (inject_copy_i != 2'd3) && ({1'b0, inject_reg_i} < 5'(NREGS));
   assign inj_live  = inj_ok && !(wr_data && (wr_idx == inj_idx));
   assign scrub_bad = (cp[0][ptr] != cp[1][ptr]) || (cp[0][ptr] != cp[2][ptr]);
   // A scrub yielding to a bus write or injection on its register is dropped and not counted.
   assign scrub_do  = scrub_bad && !(wr_data && (wr_idx == ptr)) && !(inj_ok && (inj_idx == ptr));

   always_comb begin
      wr_val = voted[wr_idx];
      for (int b = 0; b < 4; b++)
         if (wbs_sel_i[b]) wr_val[b*8 +: 8] = wbs_dat_i[b*8 +: 8];
   end

   // NOTE: the copies are real state the voter depends on, so the whole array is reset, not just control.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         for (int c = 0; c < 3; c++)
            for (int r = 0; r < NREGS; r++)
               cp[c][r] <= '0;
      end else begin
         for (int r = 0; r < NREGS; r++) begin
            for (int c = 0; c < 3; c++) begin
               if (wr_data && (wr_idx == IW'(r)))
                  cp[c][r] <= wr_val;
               else if (inj_live && (inj_idx == IW'(r)) && (inject_copy_i == 2'(c)))
                  cp[c][r][inject_bit_i] <= ~cp[c][r][inject_bit_i];
               else if (scrub_do && (ptr == IW'(r)))
                  cp[c][r] <= voted[r];
            end
         end
      end
   end

   // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         ptr      <= '0;
         err_cnt  <= '0;
         err_pend <= 1'b0;
         irq_en   <= 1'b0;
         irq_q    <= 1'b0;
         dat_q    <= '0;
         state    <= IDLE;
      end else begin
         ptr   <= (ptr == IW'(NREGS - 1)) ? '0 : ptr + 1'b1;
         state <= state_nxt;
         dat_q <= (req && !wbs_we_i) ? rd_data : '0;
         if (wr && (off == OFF_STATUS) && wbs_dat_i[31]) begin
            err_cnt  <= '0;
            err_pend <= 1'b0;
         end else if (scrub_do) begin
            if (err_cnt != 16'hFFFF) err_cnt <= err_cnt + 1'b1;
            err_pend <= 1'b1;
         end
         if (wr && (off == OFF_CTRL)) irq_en <= wbs_dat_i[0];
         irq_q <= err_pend && irq_en;
      end
   end

   always_comb begin
      rd_data = '0;
      if (off_is_data)              rd_data = voted[off[IW-1:0]];
      else if (off == OFF_STATUS)   rd_data = {err_pend, 15'b0, err_cnt};
      else if (off == OFF_CTRL)     rd_data = {31'b0, irq_en};
   end

   // NOTE: every output of this block gets a default first so no path infers a latch.
   always_comb begin
      state_nxt = state;
      wbs_ack_o = 1'b0;
      wbs_dat_o = '0;
      case (state)
         IDLE: if (req) state_nxt = ACK;
         ACK: begin
            wbs_ack_o = 1'b1;
            wbs_dat_o = dat_q;
            state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   assign irq = {2'b00, irq_q};

endmodule
